microwave_ctrl: RTL and testbench
=================================

# microwave_ctrl

Sequencing controller for the microwave timer datapath. It synchronizes the raw keypad, start/stop/clear buttons and door switch, and runs the cooking state machine. It drives the digit-load, clear and one-second decrement strobes into the existing BCD timer/7-segment datapath, and owns `mag_on`. It sits between the front-panel inputs and the timer counter. The timer reports back only `timer_zero`.

## Interface
- `TICKS_PER_SEC`, default 100: clock cycles per decrement (100 Hz system clock).
- `DONE_SECS`, default 3: seconds `done` stays asserted before returning to idle.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `keypad`  in  10  raw keys. Bit i = digit i. Asynchronous.
- `startn`, `stopn`, `clearn`  in  1 each  raw buttons, active-low. Asynchronous.
- `door_closed`  in  1  door switch, 1 = closed. Asynchronous.
- `timer_zero`  in  1  from datapath: remaining time is 0:00. Synchronous.
- `load_digit`  out  1  one-cycle strobe: shift `digit` into timer.
- `digit`  out  4  binary digit 0–9. Valid when `load_digit` is high.
- `clear_timer`  out  1  one-cycle strobe: zero the timer.
- `dec_tick`  out  1  one-cycle strobe: decrement timer by one second.
- `mag_on`  out  1  magnetron enable.
- `done`  out  1  cook-complete indicator.
- `state`  out  3  current FSM state, for debug.

## Operation
- **Input synchronization**
  - All asynchronous inputs pass through 2-flop synchronizers.
  - Reset values of the synchronizer flops: keypad 0, buttons 1, door 0.
- **Edge detection**
  - start/stop/clear events are falling edges of the synchronized signal.
  - A key event is a rising edge of the synchronized keypad vector that leaves exactly one bit set.
  - Multi-key presses are ignored.
  - `door_open` is a level, not an edge.
- **States:** IDLE, SET, COOK, PAUSE, DONE.
- **Event priority**, highest first, one action per cycle: clear > (stop | door_open in COOK) > timer_zero in COOK > start > key.
- **clear**, from any state: `clear_timer` pulse → IDLE. Prescaler is zeroed.
- **key** in IDLE, SET or DONE: `load_digit` pulse with `digit` = bit index → SET. In COOK or PAUSE: ignored.
- **start**
  - In SET or PAUSE with `door_closed`=1 and `timer_zero`=0 → COOK.
  - Otherwise ignored: no state change, no latching of a pending start.
  - A door-open start is ignored; after the door closes, a fresh start is required.
- **COOK**
  - `mag_on`=1.
  - Prescaler counts 0..TICKS_PER_SEC-1.
  - When the prescaler reaches TICKS_PER_SEC-1 and `timer_zero`=0: `dec_tick` pulses and the prescaler wraps to 0.
  - `timer_zero`=1 → DONE.
  - stop or door_open → PAUSE.
- **PAUSE**
  - `mag_on`=0.
  - Prescaler holds its value, so the partial second is preserved on resume.
- **DONE**
  - `done`=1, prescaler reused as a seconds counter.
  - After DONE_SECS×TICKS_PER_SEC cycles → IDLE.
  - key or clear exits DONE early.
- **Prescaler** clears on entry to IDLE, SET and DONE.
- **Width:** prescaler is $clog2(DONE_SECS×TICKS_PER_SEC) bits.

## Timing
- **Reset:** state=IDLE. `load_digit`, `clear_timer`, `dec_tick`, `mag_on`, `done` all 0. `digit`=0. Prescaler=0.
- **Reset mid-COOK:** `mag_on` drops asynchronously on reset assertion.
- **Input latency:** an input change sampled at edge k is visible to the FSM at edge k+2.
  - Resulting state and registered outputs update at edge k+2.
  - Example: startn falls before edge k → `mag_on`=1 after edge k+2.
- **Output style:** all outputs are registered. Strobes are exactly one cycle wide.
- **Door open during COOK:** `mag_on`=0 at most 2 edges after the door sample edge.
- **`timer_zero` during COOK:** DONE and `mag_on`=0 on the next edge. No `dec_tick` is issued in that cycle.
- **Simultaneous events:** stop and start in the same cycle resolve by priority, so stop wins.
- **Held button:** produces exactly one event.

## Structure
- **Package `microwave_pkg`:**
  - State enum (IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4).
  - Default TICKS_PER_SEC and DONE_SECS constants.
- **Sub-module `mw_input_sync`:**
  - Parameterized-width 2-flop synchronizer with registered previous-value flop.
  - Exposes synchronized level, rise and fall vectors.
  - Instantiated once for the 14 raw inputs.
- **Top:** FSM, one-hot-to-binary keypad encoder, prescaler.

## Test plan
All scenarios use TICKS_PER_SEC=4 and DONE_SECS=2.
- **Keys 3, 5, 9 with door open, then start:** three `load_digit` pulses with `digit`=3, 5, 9, state=SET, no `mag_on`. Close door, start → `mag_on`=1 at edge k+2.
- **COOK with `timer_zero` held low for 10 cycles:** `dec_tick` on cycles 4 and 8 after entry, exactly one cycle each.
- **COOK, door opened 2 cycles after a tick:** PAUSE, `mag_on`=0. Close door, start → next `dec_tick` after 2 more COOK cycles (partial second preserved).
- **COOK, stopn and startn fall in the same cycle:** state=PAUSE. A later start alone → COOK.
- **COOK, `timer_zero` raised:** DONE, `mag_on`=0, `done`=1 for 8 cycles, then IDLE. Clearn during PAUSE → one `clear_timer` pulse, IDLE.
- **Keypad 0x0A0 (two keys):** no `load_digit`. `reset` asserted mid-COOK → `mag_on`=0 immediately, state=IDLE.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared types and defaults for the microwave sequencing controller.
package microwave_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SET   = 3'd1,
      ST_COOK  = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DONE  = 3'd4
   } mw_state_e;

   localparam int DEF_TICKS_PER_SEC = 100;
   localparam int DEF_DONE_SECS     = 3;
   localparam int NUM_RAW           = 14;

   function automatic logic [3:0] onehot_to_bin(input logic [9:0] oh);
      logic [3:0] b;
      b = '0;
      for (int i = 0; i < 10; i++) begin
         if (oh[i]) b = 4'(i);
      end
      return b;
   endfunction

endpackage

// File: rtl/mw_input_sync.sv
// Two-flop synchronizer bank with a previous-value flop for edge detection.
module mw_input_sync #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   logic [WIDTH-1:0] meta;
   logic [WIDTH-1:0] prev;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta  <= RST_VAL;
         level <= RST_VAL;
         prev  <= RST_VAL;
      end else begin
         meta  <= raw;
         level <= meta;
         prev  <= level;
      end
   end

   assign rise = level & ~prev;
   assign fall = ~level & prev;

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave cooking sequencer: input sync, cook FSM, prescaler and timer strobes.
//  state | meaning
//  IDLE  | nothing entered, waiting for a digit
//  SET   | digits entered, waiting for start
//  COOK  | magnetron on, one-second decrements
//  PAUSE | stopped or door opened, partial second held
//  DONE  | cook complete indicator, timed return to IDLE
module microwave_ctrl
   import microwave_pkg::*;
#(
   parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
   parameter int DONE_SECS     = DEF_DONE_SECS
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [9:0] keypad,
   input  logic       startn,
   input  logic       stopn,
   input  logic       clearn,
   input  logic       door_closed,
   input  logic       timer_zero,
   output logic       load_digit,
   output logic [3:0] digit,
   output logic       clear_timer,
   output logic       dec_tick,
   output logic       mag_on,
   output logic       done,
   output logic [2:0] state
);

   localparam int DONE_CYC = DONE_SECS * TICKS_PER_SEC;
   localparam int PW       = (DONE_CYC > 1) ? $clog2(DONE_CYC) : 1;
   localparam logic [PW-1:0] TICK_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [PW-1:0] DONE_LAST = PW'(DONE_CYC - 1);
   localparam logic [NUM_RAW-1:0] SYNC_RST = {1'b0, 3'b111, 10'b0};

   logic [NUM_RAW-1:0] lvl, rise, fall;
   logic       unused_sync;
   logic [9:0] key_lvl;
   logic       key_ev, start_ev, stop_ev, clear_ev, door_open;

   mw_input_sync #(.WIDTH(NUM_RAW), .RST_VAL(SYNC_RST)) u_sync (
      .clock (clock),
      .reset (reset),
      .raw   ({door_closed, clearn, stopn, startn, keypad}),
      .level (lvl),
      .rise  (rise),
      .fall  (fall)
   );

   assign key_lvl   = lvl[9:0];
   assign key_ev    = (|rise[9:0]) && $onehot(key_lvl);
   assign start_ev  = fall[10];
   assign stop_ev   = fall[11];
   assign clear_ev  = fall[12];
   assign door_open = ~lvl[13];
   assign unused_sync = ^{lvl[12:10], rise[13:10], fall[9:0], fall[13]};

   mw_state_e     st_q, st_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [3:0]    digit_d;
   logic          load_d, clr_d, dec_d;

   always_comb begin
      st_d    = st_q;
      pre_d   = pre_q;
      digit_d = digit;
      load_d  = 1'b0;
      clr_d   = 1'b0;
      dec_d   = 1'b0;
      if (clear_ev) begin
         st_d  = ST_IDLE;
         clr_d = 1'b1;
         pre_d = '0;
      end else if (st_q == ST_COOK && (stop_ev || door_open)) begin
         st_d = ST_PAUSE;
      end else if (st_q == ST_COOK && timer_zero) begin
         st_d  = ST_DONE;
         pre_d = '0;
      end else if (start_ev && (st_q == ST_SET || st_q == ST_PAUSE) &&
                   !door_open && !timer_zero) begin
         st_d = ST_COOK;
      end else if (key_ev && (st_q == ST_IDLE || st_q == ST_SET || st_q == ST_DONE)) begin
         st_d    = ST_SET;
         load_d  = 1'b1;
         digit_d = onehot_to_bin(key_lvl);
         pre_d   = '0;
      end else if (st_q == ST_COOK) begin
         if (pre_q == TICK_LAST) begin
            dec_d = 1'b1;
            pre_d = '0;
         end else begin
            pre_d = pre_q + 1'b1;
         end
      end else if (st_q == ST_DONE) begin
         // prescaler doubles as the done-display timer
         if (pre_q == DONE_LAST) begin
            st_d  = ST_IDLE;
            pre_d = '0;
         end else begin
            pre_d = pre_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         st_q        <= ST_IDLE;
         pre_q       <= '0;
         load_digit  <= 1'b0;
         digit       <= '0;
         clear_timer <= 1'b0;
         dec_tick    <= 1'b0;
         mag_on      <= 1'b0;
         done        <= 1'b0;
      end else begin
         st_q        <= st_d;
         pre_q       <= pre_d;
         load_digit  <= load_d;
         digit       <= digit_d;
         clear_timer <= clr_d;
         dec_tick    <= dec_d;
         mag_on      <= (st_d == ST_COOK);
         done        <= (st_d == ST_DONE);
      end
   end

   assign state = st_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Self-checking bench for microwave_ctrl with a cycle-level behavioural model.
module tb_microwave_ctrl;

   localparam int T  = 4;
   localparam int DS = 2;
   localparam int M_IDLE = 0, M_SET = 1, M_COOK = 2, M_PAUSE = 3, M_DONE = 4;
   localparam logic [13:0] HIST_RST = {1'b0, 3'b111, 10'b0};

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] keypad = '0;
   logic       startn = 1'b1, stopn = 1'b1, clearn = 1'b1;
   logic       door_closed = 1'b0, timer_zero = 1'b0;
   logic       load_digit, clear_timer, dec_tick, mag_on, done;
   logic [3:0] digit;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   microwave_ctrl #(.TICKS_PER_SEC(T), .DONE_SECS(DS)) dut (
      .clock       (clock),
      .reset       (reset),
      .keypad      (keypad),
      .startn      (startn),
      .stopn       (stopn),
      .clearn      (clearn),
      .door_closed (door_closed),
      .timer_zero  (timer_zero),
      .load_digit  (load_digit),
      .digit       (digit),
      .clear_timer (clear_timer),
      .dec_tick    (dec_tick),
      .mag_on      (mag_on),
      .done        (done),
      .state       (state)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: raw samples reach the decision logic two edges later; hist[0] is newest.
   logic [13:0] hist [3] = '{HIST_RST, HIST_RST, HIST_RST};
   int m_mode = M_IDLE;
   int m_phase = 0;
   int m_left = 0;
   int e_digit = 0;
   bit e_load = 0, e_clr = 0, e_dec = 0;

   initial begin : model_p
      logic [13:0] lv, pv;
      bit ev_clr, ev_stp, ev_sta, ev_key, closed;
      forever begin
         @(posedge clock or posedge reset);
         if (reset) begin
            for (int i = 0; i < 3; i++) hist[i] = HIST_RST;
            m_mode = M_IDLE; m_phase = 0; m_left = 0;
            e_load = 0; e_clr = 0; e_dec = 0; e_digit = 0;
         end else begin
            lv = hist[1];
            pv = hist[2];
            ev_clr = pv[12] && !lv[12];
            ev_stp = pv[11] && !lv[11];
            ev_sta = pv[10] && !lv[10];
            closed = lv[13];
            ev_key = (|(lv[9:0] & ~pv[9:0])) && ($countones(lv[9:0]) == 1);
            e_load = 0; e_clr = 0; e_dec = 0;
            if (ev_clr) begin
               m_mode = M_IDLE; m_phase = 0; e_clr = 1;
            end else if (m_mode == M_COOK && (ev_stp || !closed)) begin
               m_mode = M_PAUSE;
            end else if (m_mode == M_COOK && timer_zero) begin
               m_mode = M_DONE; m_left = DS * T;
            end else if (ev_sta && (m_mode == M_SET || m_mode == M_PAUSE) && closed && !timer_zero) begin
               m_mode = M_COOK;
            end else if (ev_key && m_mode != M_COOK && m_mode != M_PAUSE) begin
               e_load = 1;
               for (int i = 0; i < 10; i++) if (lv[i]) e_digit = i;
               m_mode = M_SET; m_phase = 0;
            end else if (m_mode == M_COOK) begin
               m_phase++;
               if (m_phase == T) begin e_dec = 1; m_phase = 0; end
            end else if (m_mode == M_DONE) begin
               m_left--;
               if (m_left == 0) m_mode = M_IDLE;
            end
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = {door_closed, clearn, stopn, startn, keypad};
         end
      end
   end

   int dig_q[$];

   initial begin : compare_p
      forever begin
         @(negedge clock);
         if (!reset) begin
            chk("state", int'(state), m_mode);
            chk("load_digit", int'(load_digit), int'(e_load));
            if (e_load) chk("digit", int'(digit), e_digit);
            chk("clear_timer", int'(clear_timer), int'(e_clr));
            chk("dec_tick", int'(dec_tick), int'(e_dec));
            chk("mag_on", int'(mag_on), int'(m_mode == M_COOK));
            chk("done", int'(done), int'(m_mode == M_DONE));
            if (load_digit) dig_q.push_back(int'(digit));
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic press_key(input int k);
      keypad = 10'(1 << k);
      cyc(3);
      keypad = '0;
      cyc(2);
   endtask

   initial begin : stim_p
      int ticks[$];
      int n;
      bit seen;

      cyc(3);
      reset = 1'b0;
      cyc(2);
      chk("rst_state", int'(state), 0);
      chk("rst_mag", int'(mag_on), 0);

      // digits with door open, then a start that must be ignored
      press_key(3); press_key(5); press_key(9);
      cyc(2);
      chk("set_state", int'(state), 1);
      chk("set_mag", int'(mag_on), 0);
      chk("dig_count", dig_q.size(), 3);
      chk("dig0", dig_q.size() > 0 ? dig_q[0] : -1, 3);
      chk("dig1", dig_q.size() > 1 ? dig_q[1] : -1, 5);
      chk("dig2", dig_q.size() > 2 ? dig_q[2] : -1, 9);
      startn = 1'b0; cyc(3); startn = 1'b1; cyc(3);
      chk("start_door_open", int'(state), 1);

      door_closed = 1'b1; cyc(3);
      startn = 1'b0;
      cyc(2); chk("mag_k1", int'(mag_on), 0);
      cyc(1); chk("mag_k2", int'(mag_on), 1);
      startn = 1'b1;

      for (int i = 1; i <= 10; i++) begin
         cyc(1);
         if (dec_tick) ticks.push_back(i);
      end
      chk("tick_count", ticks.size(), 2);
      chk("tick_first", ticks.size() > 0 ? ticks[0] : -1, 4);
      chk("tick_second", ticks.size() > 1 ? ticks[1] : -1, 8);

      // door opens right after a tick; partial second must survive the pause
      n = 0; seen = 0;
      while (!seen && n < 8) begin
         cyc(1); n++; seen = dec_tick;
      end
      chk("tick_wait", int'(seen), 1);
      door_closed = 1'b0;
      cyc(2); chk("door_mag_still", int'(mag_on), 1);
      cyc(1); chk("door_pause", int'(state), 3);
      chk("door_mag", int'(mag_on), 0);
      door_closed = 1'b1; cyc(3);
      startn = 1'b0; cyc(3);
      chk("resume", int'(state), 2);
      startn = 1'b1;
      cyc(1); chk("resume_t1", int'(dec_tick), 0);
      cyc(1); chk("resume_t2", int'(dec_tick), 1);

      // stop and start together: stop wins
      stopn = 1'b0; startn = 1'b0; cyc(3);
      chk("stop_start", int'(state), 3);
      stopn = 1'b1; startn = 1'b1; cyc(3);
      startn = 1'b0; cyc(3);
      chk("restart", int'(state), 2);
      startn = 1'b1; cyc(2);

      // timer reaches zero
      timer_zero = 1'b1; cyc(1);
      chk("done_state", int'(state), 4);
      chk("done_mag", int'(mag_on), 0);
      chk("done_flag", int'(done), 1);
      chk("done_no_tick", int'(dec_tick), 0);
      n = 1;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (!done) break;
         n++;
      end
      chk("done_len", n, 8);
      chk("done_idle", int'(state), 0);
      timer_zero = 1'b0;

      // clear during pause, held button gives one pulse
      press_key(1);
      startn = 1'b0; cyc(3); startn = 1'b1;
      chk("cook2", int'(state), 2);
      cyc(2);
      stopn = 1'b0; cyc(3);
      chk("pause2", int'(state), 3);
      stopn = 1'b1; cyc(2);
      clearn = 1'b0; n = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(1);
         if (clear_timer) n++;
      end
      chk("clear_pulses", n, 1);
      chk("clear_idle", int'(state), 0);
      clearn = 1'b1; cyc(3);

      // two keys at once produce nothing
      keypad = 10'h0A0; n = 0;
      for (int i = 0; i < 9; i++) begin
         if (i == 6) keypad = '0;
         cyc(1);
         if (load_digit) n++;
      end
      chk("multikey_load", n, 0);
      chk("multikey_state", int'(state), 0);

      // reset mid-cook
      press_key(7);
      startn = 1'b0; cyc(3); startn = 1'b1;
      chk("cook3", int'(mag_on), 1);
      cyc(2);
      reset = 1'b1; #1;
      chk("rst_async_mag", int'(mag_on), 0);
      chk("rst_async_state", int'(state), 0);
      cyc(2);
      reset = 1'b0; cyc(3);
      chk("post_rst", int'(state), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
